// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 types and widths for the slave write path.
// The FIFO word width defaults to DATA_WIDTH defined here.
package axi4_globals_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi4_resp_e;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi4_burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } axi4_slv_wr_state_e;

  // WRAP (2'b10) and the reserved code (2'b11) both have bit 1 set.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; full and empty come from the count.
// Reading is show-ahead: o_rd_data is the head entry whenever o_empty is low.
module axi4_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;

endmodule

// File: rtl/axi4_slave_write_fifo.sv
// AXI4 write responder: accepts one AW/W/B transaction at a time and stores
// strobe-masked beats in a local FIFO that is drained through a pop port.
module axi4_slave_write_fifo #(
  parameter int DATA_WIDTH = axi4_globals_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [7:0]              awid,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [7:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic                    fifo_rd_en,
  output logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [CW-1:0]           fifo_count,
  output logic [1:0]              o_dbg_state
);

  import axi4_globals_pkg::*;

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // Once valid is raised the master holds it and its payload until accepted.
  axi4_slv_wr_state_e r_state;
  axi4_slv_wr_state_e w_next_state;

  logic                  r_rdy_en;
  logic [7:0]            r_id;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_err;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_aw_bad;
  logic                  w_last_beat;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_masked;

  assign w_aw_hs     = awvalid && awready;
  assign w_w_hs      = wvalid && wready;
  assign w_b_hs      = bvalid && bready;
  assign w_aw_bad    = (awsize > SIZE_MAX) || burst_unsupported(awburst);
  assign w_last_beat = (r_beat == r_len);
  assign w_push      = w_w_hs && !r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs) w_next_state = DATA;
      DATA:    if (w_w_hs && w_last_beat) w_next_state = RESP;
      RESP:    if (w_b_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Errored bursts keep wready high so every beat drains even with a full FIFO.
  always_comb begin
    awready = (r_state == IDLE) && r_rdy_en;
    wready  = (r_state == DATA) && (r_err || !fifo_full);
    bvalid  = (r_state == RESP);
  end

  // The burst length comes only from the latched awlen; wlast is only checked.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en <= 1'b0;
      r_id     <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_aw_hs) begin
        r_id   <= awid;
        r_len  <= awlen;
        r_beat <= '0;
        r_err  <= w_aw_bad;
      end else if (w_w_hs) begin
        if (w_last_beat) begin
          if (!wlast) r_err <= 1'b1;
        end else begin
          if (wlast) r_err <= 1'b1;
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_masked[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : 8'h00;
    end
  end

  assign bid         = r_id;
  assign bresp       = r_err ? SLVERR : OKAY;
  assign o_dbg_state = r_state;

  axi4_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_push      (w_push),
    .i_push_data (w_masked),
    .i_pop       (fifo_rd_en),
    .o_rd_data   (fifo_rd_data),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full),
    .o_count     (fifo_count)
  );

endmodule

// File: tb/tb_axi4_slave_write_fifo.sv
// Directed bench for axi4_slave_write_fifo: a transaction-level model checks every
// cycle on the falling edge, and directed sequences add literal expectations.
module tb_axi4_slave_write_fifo;

  import axi4_globals_pkg::*;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [7:0]    awid = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [7:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic          fifo_rd_en = 1'b0;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [1:0]    dbg_state;

  axi4_slave_write_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CW         (CW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .awid         (awid),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bid          (bid),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .o_dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected FIFO contents plus the current transaction phase.
  logic [DW-1:0] exp_q[$];
  int            m_phase = 0;  // 0 waiting for AW, 1 taking beats, 2 responding
  bit            m_live  = 0;
  bit            m_err   = 0;
  logic [7:0]    m_id    = '0;
  int            m_len   = 0;
  int            m_idx   = 0;
  bit            e_awr, e_wr, e_bv;

  function automatic logic [DW-1:0] strobe_mask(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      m_phase = 0;
      m_live  = 0;
      m_err   = 0;
      m_id    = '0;
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bid", bid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
    end else begin
      e_awr = (m_phase == 0) && m_live;
      e_wr  = (m_phase == 1) && (m_err || exp_q.size() < DEPTH);
      e_bv  = (m_phase == 2);
      chk("m_awready", awready, e_awr);
      chk("m_wready", wready, e_wr);
      chk("m_bvalid", bvalid, e_bv);
      chk("m_count", fifo_count, exp_q.size());
      chk("m_empty", fifo_empty, exp_q.size() == 0);
      chk("m_full", fifo_full, exp_q.size() == DEPTH);
      if (exp_q.size() > 0) chk("m_rd_data", fifo_rd_data, exp_q[0]);
      if (e_bv) begin
        chk("m_bid", bid, m_id);
        chk("m_bresp", bresp, m_err ? 2'b10 : 2'b00);
      end
      if (fifo_rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      case (m_phase)
        0: if (awvalid && e_awr) begin
             m_id    = awid;
             m_len   = int'(awlen);
             m_idx   = 0;
             m_err   = (awsize > 3'd2) || (awburst >= 2'd2);
             m_phase = 1;
           end
        1: if (wvalid && e_wr) begin
             if (!m_err) exp_q.push_back(strobe_mask(wdata, wstrb));
             if (m_idx == m_len) begin
               if (!wlast) m_err = 1;
               m_phase = 2;
             end else begin
               if (wlast) m_err = 1;
               m_idx++;
             end
           end
        default: if (bready) m_phase = 0;
      endcase
      m_live = 1;
    end
  end

  // Driver tasks: all are entered just after a rising edge.
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    bit ok;
    ok = 0;
    awid = id; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (awready) begin ok = 1; break; end
    end
    chk("aw_handshake_in_budget", ok, 1);
    tick;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    bit ok;
    ok = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (wready) begin ok = 1; break; end
    end
    chk("w_handshake_in_budget", ok, 1);
    tick;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_check(input string name, input logic [7:0] id, input logic [1:0] resp);
    @(negedge aclk);
    chk({name, "_bvalid"}, bvalid, 1);
    chk({name, "_bid"}, bid, id);
    chk({name, "_bresp"}, bresp, resp);
    tick;
  endtask

  task automatic pop_check(input string name, input logic [DW-1:0] d);
    fifo_rd_en = 1'b1;
    @(negedge aclk);
    chk(name, fifo_rd_data, d);
    tick;
    fifo_rd_en = 1'b0;
  endtask

  task automatic drain;
    fifo_rd_en = 1'b1;
    repeat (DEPTH + 2) tick;
    fifo_rd_en = 1'b0;
    @(negedge aclk);
    chk("drain_empty", fifo_empty, 1);
    tick;
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("t1_rst_awready", awready, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("t1_awready_before_edge", awready, 0);
    @(negedge aclk);
    chk("t1_awready_after_edge", awready, 1);
    tick;

    // INCR burst of 4 with full strobes
    aw_send(8'h5A, 8'd3, 3'd2, INCR);
    for (int i = 1; i <= 4; i++) w_send(DW'(i), 4'hF, i == 4);
    b_check("t2", 8'h5A, 2'b00);
    @(negedge aclk);
    chk("t2_count", fifo_count, 4);
    tick;
    for (int i = 1; i <= 4; i++) pop_check("t2_pop", DW'(i));

    // 20-beat burst overflows the 16-entry FIFO until it is popped
    aw_send(8'h33, 8'd19, 3'd2, INCR);
    for (int i = 0; i < 16; i++) w_send(DW'(100 + i), 4'hF, 1'b0);
    @(negedge aclk);
    chk("t3_full", fifo_full, 1);
    chk("t3_wready_low", wready, 0);
    chk("t3_count", fifo_count, 16);
    tick;
    for (int i = 0; i < 4; i++) pop_check("t3_pop", DW'(100 + i));
    for (int i = 16; i < 20; i++) w_send(DW'(100 + i), 4'hF, i == 19);
    b_check("t3", 8'h33, 2'b00);
    drain;

    // wlast too early, then wlast missing on the final beat
    aw_send(8'h41, 8'd3, 3'd2, INCR);
    w_send(32'h11, 4'hF, 1'b0);
    w_send(32'h22, 4'hF, 1'b1);
    w_send(32'h33, 4'hF, 1'b0);
    w_send(32'h44, 4'hF, 1'b1);
    b_check("t4a", 8'h41, 2'b10);
    @(negedge aclk);
    chk("t4a_count", fifo_count, 2);
    tick;
    drain;
    aw_send(8'h42, 8'd1, 3'd2, INCR);
    w_send(32'h55, 4'hF, 1'b0);
    w_send(32'h66, 4'hF, 1'b0);
    b_check("t4b", 8'h42, 2'b10);
    drain;

    // Unsupported burst and size, then partial strobes
    aw_send(8'h50, 8'd1, 3'd2, WRAP);
    w_send(32'h77, 4'hF, 1'b0);
    w_send(32'h88, 4'hF, 1'b1);
    b_check("t5_wrap", 8'h50, 2'b10);
    @(negedge aclk);
    chk("t5_wrap_count", fifo_count, 0);
    tick;
    aw_send(8'h51, 8'd0, 3'd3, INCR);
    w_send(32'h99, 4'hF, 1'b1);
    b_check("t5_size", 8'h51, 2'b10);
    aw_send(8'h52, 8'd0, 3'd2, INCR);
    w_send(32'hAABBCCDD, 4'b0101, 1'b1);
    b_check("t5_strb", 8'h52, 2'b00);
    pop_check("t5_strb_data", 32'h00BB00DD);

    // Push and pop together at count 5, then hold bready low
    aw_send(8'h60, 8'd4, 3'd2, INCR);
    for (int i = 0; i < 5; i++) w_send(DW'(200 + i), 4'hF, i == 4);
    b_check("t6a", 8'h60, 2'b00);
    aw_send(8'h61, 8'd0, 3'd2, FIXED);
    bready = 1'b0;
    wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    fifo_rd_en = 1'b1;
    @(negedge aclk);
    chk("t6_wready", wready, 1);
    chk("t6_count_before", fifo_count, 5);
    tick;
    wvalid = 1'b0; wlast = 1'b0; fifo_rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("t6_count_after", fifo_count, 5);
      chk("t6_bvalid_held", bvalid, 1);
      chk("t6_awready_low", awready, 0);
    end
    tick;
    bready = 1'b1;
    @(negedge aclk);
    chk("t6_bid", bid, 8'h61);
    tick;
    @(negedge aclk);
    chk("t6_bvalid_done", bvalid, 0);
    chk("t6_awready_back", awready, 1);
    tick;
    drain;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
